// File: rtl/core_sequencer.sv
// core_sequencer: drives core.inst cycle by cycle for one conv tile.
// Define SEQ_ACC_EN to include the SFP accumulation (ACC) phase.
module core_sequencer #(
  parameter int          ROW      = 8,
  parameter int          COL      = 8,
  parameter int          IN_W     = 6,
  parameter int          K_W      = 3,
  parameter int          OUT_W    = 4,
  parameter logic [10:0] W_BASE   = 11'd1024,
  parameter logic [10:0] ACT_BASE = 11'd0,
  parameter logic [10:0] P_BASE   = 11'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij
);

  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_KIJ  = K_W * K_W;
  localparam int LEN_ONIJ = OUT_W * OUT_W;
  localparam int M1 = (LEN_NIJ > ROW + COL) ? LEN_NIJ : ROW + COL;
  localparam int M2 = (M1 > LEN_ONIJ) ? M1 : LEN_ONIJ;
  localparam int CW = $clog2(M2 + 2) + 1;

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] C_COL    = CW'(COL);
  localparam logic [CW-1:0] C_COL_M1 = CW'(COL - 1);
  localparam logic [CW-1:0] C_GAP_M1 = CW'(ROW + COL - 1);
  localparam logic [CW-1:0] C_NIJ    = CW'(LEN_NIJ);
  localparam logic [CW-1:0] C_NIJ_M1 = CW'(LEN_NIJ - 1);
  localparam logic [3:0]    C_KIJ_LAST = 4'(LEN_KIJ - 1);
`ifdef SEQ_ACC_EN
  localparam logic [CW-1:0] C_KIJ    = CW'(LEN_KIJ);
  localparam logic [CW-1:0] C_KIJ_M1 = CW'(LEN_KIJ - 1);
  localparam logic [CW-1:0] C_KW_M1  = CW'(K_W - 1);
  localparam logic [CW-1:0] C_OW_M1  = CW'(OUT_W - 1);
`endif

  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    IDLE, W_RD, W_LOAD, W_GAP, A_RD, EXEC, DRAIN,
`ifdef SEQ_ACC_EN
    ACC,
`endif
    FIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [3:0]    kij_q, kij_d;
  logic [33:0]   inst_q, inst_d;
  logic          busy_q, done_q;
`ifdef SEQ_ACC_EN
  logic [CW-1:0] orow_q, orow_d, ocol_q, ocol_d;
  logic [CW-1:0] krow_q, krow_d, kcol_q, kcol_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    kij_d   = kij_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
`ifdef SEQ_ACC_EN
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    krow_d  = krow_q;
    kcol_d  = kcol_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = W_RD;
          cnt_d   = '0;
          kij_d   = '0;
        end
      end
      W_RD: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == C_COL) begin
          state_d = W_LOAD;
          cnt_d   = '0;
        end
      end
      W_LOAD: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == C_COL_M1) begin
          state_d = W_GAP;
          cnt_d   = '0;
        end
      end
      W_GAP: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == C_GAP_M1) begin
          state_d = A_RD;
          cnt_d   = '0;
        end
      end
      A_RD: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == C_NIJ) begin
          state_d = EXEC;
          cnt_d   = '0;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == C_NIJ_M1) begin
          state_d = DRAIN;
          rd_d    = ofifo_valid;
          cnt_d   = {{(CW-1){1'b0}}, ofifo_valid};
          wcnt_d  = '0;
        end
      end
      DRAIN: begin
        // cnt counts ofifo reads issued; wcnt indexes the pmem writes
        wr_d   = rd_q;
        wcnt_d = wr_q ? wcnt_q + ONE : wcnt_q;
        rd_d   = ofifo_valid && (cnt_q < C_NIJ);
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, rd_d};
        if (wr_q && (wcnt_q == C_NIJ_M1)) begin
          rd_d  = 1'b0;
          wr_d  = 1'b0;
          cnt_d = '0;
          if (kij_q == C_KIJ_LAST) begin
`ifdef SEQ_ACC_EN
            state_d = ACC;
            orow_d  = '0;
            ocol_d  = '0;
            krow_d  = '0;
            kcol_d  = '0;
`else
            state_d = FIN;
`endif
          end else begin
            state_d = W_RD;
            kij_d   = kij_q + 4'd1;
          end
        end
      end
`ifdef SEQ_ACC_EN
      ACC: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == C_KIJ) begin
          cnt_d = '0;
          if (ocol_q == C_OW_M1) begin
            ocol_d = '0;
            orow_d = orow_q + ONE;
          end else begin
            ocol_d = ocol_q + ONE;
          end
          if ((orow_q == C_OW_M1) && (ocol_q == C_OW_M1))
            state_d = FIN;
        end else if (kcol_q == C_KW_M1) begin
          kcol_d = '0;
          krow_d = (cnt_q == C_KIJ_M1) ? '0 : krow_q + ONE;
        end else begin
          kcol_d = kcol_q + ONE;
        end
      end
`endif
      FIN: begin
        state_d = IDLE;
        kij_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inst_d = IDLE_INST;
    unique case (state_d)
      W_RD: begin
        if (cnt_d < C_COL) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = W_BASE + 11'(kij_d * COL) + 11'(cnt_d);
        end
        inst_d[2] = (cnt_d != '0);
      end
      W_LOAD: begin
        inst_d[3] = 1'b1;
        inst_d[0] = 1'b1;
      end
      A_RD: begin
        if (cnt_d < C_NIJ) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = ACT_BASE + 11'(cnt_d);
        end
        inst_d[2] = (cnt_d != '0);
      end
      EXEC: begin
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
      end
      DRAIN: begin
        inst_d[6] = rd_d;
        if (wr_d) begin
          inst_d[32]    = 1'b0;
          inst_d[31]    = 1'b0;
          inst_d[30:20] = P_BASE + 11'(kij_d * LEN_NIJ) + 11'(wcnt_d);
        end
      end
`ifdef SEQ_ACC_EN
      ACC: begin
        if (cnt_d < C_KIJ) begin
          inst_d[32]    = 1'b0;
          inst_d[30:20] = P_BASE + 11'(cnt_d * LEN_NIJ)
                        + 11'((orow_d + krow_d) * IN_W + ocol_d + kcol_d);
        end
      end
`endif
      default: ;
    endcase
`ifdef SEQ_ACC_EN
    // pmem data of a read lands one cycle later; the gap has no read
    inst_d[33] = (state_q == ACC) && (cnt_q < C_KIJ);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      kij_q   <= '0;
      inst_q  <= IDLE_INST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_ACC_EN
      orow_q  <= '0;
      ocol_q  <= '0;
      krow_q  <= '0;
      kcol_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      kij_q   <= kij_d;
      inst_q  <= inst_d;
      busy_q  <= (state_d != IDLE) && (state_d != FIN);
      done_q  <= (state_d == FIN);
`ifdef SEQ_ACC_EN
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      krow_q  <= krow_d;
      kcol_q  <= kcol_d;
`endif
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign kij  = kij_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: vector table plus address scoreboard for core_sequencer.
// Follows SEQ_ACC_EN the same way as the design.
module tb_core_sequencer;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij;

  int checks   = 0;
  int failures = 0;

  core_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .ofifo_valid(ofifo_valid), .inst(inst),
    .busy(busy), .done(done), .kij(kij)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [33:0] i;
    logic        b;
    logic        d;
    logic [3:0]  kj;
  } vec_t;

  vec_t vecs[$];
  int   xq[$];
  int   wq[$];
  int   aq[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [33:0] xrd(input int a, input bit wr);
    logic [33:0] w = IDLE_W;
    w[19]   = 1'b0;
    w[17:7] = 11'(a);
    w[2]    = wr;
    return w;
  endfunction

  function automatic logic [33:0] wrd(input logic [33:0] bits);
    return IDLE_W | bits;
  endfunction

  function automatic logic [33:0] dr(input bit rd, input bit wr, input int a);
    logic [33:0] w = IDLE_W;
    w[6] = rd;
    if (wr) begin
      w[32]    = 1'b0;
      w[31]    = 1'b0;
      w[30:20] = 11'(a);
    end
    return w;
  endfunction

  function automatic logic [33:0] ar(input bit acc, input bit rd, input int a);
    logic [33:0] w = IDLE_W;
    w[33] = acc;
    if (rd) begin
      w[32]    = 1'b0;
      w[30:20] = 11'(a);
    end
    return w;
  endfunction

  task automatic add(input int k, input logic [33:0] i, input logic b,
                     input logic d, input logic [3:0] kj);
    vec_t v;
    v.k = k; v.i = i; v.b = b; v.d = d; v.kj = kj;
    vecs.push_back(v);
  endtask

  task automatic fill_queues();
    xq.delete(); wq.delete(); aq.delete();
    for (int kj = 0; kj < 9; kj++) begin
      for (int c = 0; c < 8; c++) xq.push_back(1024 + kj * 8 + c);
      for (int n = 0; n < 36; n++) xq.push_back(n);
      for (int p = 0; p < 36; p++) wq.push_back(kj * 36 + p);
    end
`ifdef SEQ_ACC_EN
    for (int o = 0; o < 16; o++)
      for (int k = 0; k < 9; k++)
        aq.push_back(k * 36 + (o / 4 + k / 3) * 6 + (o % 4 + k % 3));
`endif
  endtask

  task automatic mon(input logic [33:0] prev);
    logic wr_now;
    logic rd_now;
    wr_now = !inst[32] && !inst[31];
    rd_now = !inst[32] && inst[31];
    chk("ififo_bits", 64'(inst[5:4]), 64'd0);
    chk("wen_xmem", 64'(inst[18]), 64'd1);
    chk("pmem_wr_after_rd", 64'(wr_now), 64'(prev[6]));
`ifdef SEQ_ACC_EN
    chk("acc_after_read", 64'(inst[33]), 64'(!prev[32] && prev[31]));
`else
    chk("acc_zero", 64'(inst[33]), 64'd0);
`endif
    if (!inst[19]) begin
      if (xq.size() == 0) begin
        checks++; failures++;
        $display("FAIL xmem_extra: got %0d expected none", inst[17:7]);
      end else chk("xmem_addr", 64'(inst[17:7]), 64'(xq.pop_front()));
    end
    if (wr_now) begin
      if (wq.size() == 0) begin
        checks++; failures++;
        $display("FAIL pmem_wr_extra: got %0d expected none", inst[30:20]);
      end else chk("pmem_wr_addr", 64'(inst[30:20]), 64'(wq.pop_front()));
    end
    if (rd_now) begin
      if (aq.size() == 0) begin
        checks++; failures++;
        $display("FAIL pmem_rd_extra: got %0d expected none", inst[30:20]);
      end else chk("pmem_rd_addr", 64'(inst[30:20]), 64'(aq.pop_front()));
    end
  endtask

  task automatic run_tile(input bit use_vecs, input bit stall);
    int vi    = 0;
    int ndone = 0;
    int fin_k = -1;
    logic [33:0] prev = IDLE_W;
    fill_queues();
    ofifo_valid = 1'b1;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      start = 1'b0;
      mon(prev);
      prev = inst;
      if (use_vecs && vi < vecs.size() && vecs[vi].k == k) begin
        chk($sformatf("vec%0d_inst", k), 64'(inst), 64'(vecs[vi].i));
        chk($sformatf("vec%0d_busy", k), 64'(busy), 64'(vecs[vi].b));
        chk($sformatf("vec%0d_done", k), 64'(done), 64'(vecs[vi].d));
        chk($sformatf("vec%0d_kij", k), 64'(kij), 64'(vecs[vi].kj));
        vi++;
      end
      if (done) begin
        ndone++;
        chk("busy_low_at_done", 64'(busy), 64'd0);
        if (fin_k < 0) fin_k = k;
      end
      if (stall && k >= 106 && k <= 125) begin
        chk("stall_no_ofifo_rd", 64'(inst[6]), 64'd0);
        chk("stall_cen_pmem", 64'(inst[32]), 64'd1);
      end
      if (use_vecs && k == 500) start = 1'b1;
      if (stall) begin
        if (k == 100) ofifo_valid = 1'b0;
        else if (k == 125) ofifo_valid = 1'b1;
        else if (k >= 143 && fin_k < 0) ofifo_valid = 1'($urandom_range(0, 1));
      end
      if (fin_k >= 0 && k == fin_k + 2) break;
    end
    if (fin_k < 0) begin
      checks++; failures++;
      $display("FAIL tile_timeout: got no done expected done");
    end
    chk("xmem_left", 64'(xq.size()), 64'd0);
    chk("pmem_wr_left", 64'(wq.size()), 64'd0);
    chk("pmem_rd_left", 64'(aq.size()), 64'd0);
    chk("done_pulses", 64'(ndone), 64'd1);
    if (use_vecs) chk("vectors_seen", 64'(vi), 64'(vecs.size()));
  endtask

  initial begin
    int last;
    // expected words, k counted from the first cycle after the start edge
    for (int c = 0; c <= 8; c++)
      add(c, (c < 8) ? xrd(1024 + c, c > 0) : wrd(34'h4), 1, 0, 0);
    for (int c = 0; c < 8; c++) add(9 + c, wrd(34'h9), 1, 0, 0);
    add(17, IDLE_W, 1, 0, 0);
    add(32, IDLE_W, 1, 0, 0);
    add(33, xrd(0, 0), 1, 0, 0);
    add(34, xrd(1, 1), 1, 0, 0);
    add(69, wrd(34'h4), 1, 0, 0);
    add(70, wrd(34'hA), 1, 0, 0);
    add(105, wrd(34'hA), 1, 0, 0);
    add(106, dr(1, 0, 0), 1, 0, 0);
    add(107, dr(1, 1, 0), 1, 0, 0);
    add(141, dr(1, 1, 34), 1, 0, 0);
    add(142, dr(0, 1, 35), 1, 0, 0);
    add(143, xrd(1032, 0), 1, 0, 1);
    add(1286, dr(0, 1, 323), 1, 0, 8);
`ifdef SEQ_ACC_EN
    add(1287, ar(0, 1, 0), 1, 0, 8);
    add(1288, ar(1, 1, 37), 1, 0, 8);
    add(1296, ar(1, 0, 0), 1, 0, 8);
    add(1297, ar(0, 1, 1), 1, 0, 8);
    add(1341, ar(1, 1, 158), 1, 0, 8);
    add(1342, ar(1, 1, 195), 1, 0, 8);
    last = 1447;
`else
    last = 1287;
`endif
    add(last, IDLE_W, 0, 1, 8);
    add(last + 1, IDLE_W, 0, 0, 0);

    reset = 1'b0;
    start = 1'b1;
    ofifo_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_inst", 64'(inst), 64'(IDLE_W));
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_kij", 64'(kij), 64'd0);
    end
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);

    run_tile(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    run_tile(1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // async reset in EXEC of kij 1
    ofifo_valid = 1'b1;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 223; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_exec", 64'(inst), 64'(wrd(34'hA)));
    chk("pre_rst_kij", 64'(kij), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_inst", 64'(inst), 64'(IDLE_W));
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_kij", 64'(kij), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("restart_inst", 64'(inst), 64'(xrd(1024, 0)));
    chk("restart_kij", 64'(kij), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Instruction sequencer for the systolic-array `core`: drives the 34-bit `inst` word cycle by cycle so one full 3x3 convolution tile runs without a testbench.
- For each kernel position kij it loads weights from xmem through L0 into the PE array, then streams activations, executes, and drains the OFIFO into pmem.
- It then accumulates the partial sums per output pixel through the SFP.
- It sits between the top-level start/status interface and `core.inst`.

## Interface
- `ROW`, 8, PE rows (L0 width in bw-words)
- `COL`, 8, PE columns
- `IN_W`, 6, input feature-map width; LEN_NIJ = IN_W*IN_W
- `K_W`, 3, kernel width; LEN_KIJ = K_W*K_W
- `OUT_W`, 4, output width; LEN_ONIJ = OUT_W*OUT_W
- `W_BASE`, 11'd1024, xmem base address of weights; kij block at W_BASE + kij*COL
- `ACT_BASE`, 11'd0, xmem base address of activations
- `P_BASE`, 11'd0, pmem base; psum for (kij,nij) at P_BASE + kij*LEN_NIJ + nij

Ports:
- `clk` in 1 — sole clock, rising edge
- `reset` in 1 — asynchronous, active-low
- `start` in 1 — begin one tile; sampled only in IDLE
- `ofifo_valid` in 1 — from core; OFIFO holds at least one full row
- `inst` out 34 — core instruction word, registered:
  - [33] acc
  - [32] CEN_pmem
  - [31] WEN_pmem
  - [30:20] A_pmem
  - [19] CEN_xmem
  - [18] WEN_xmem
  - [17:7] A_xmem
  - [6] ofifo_rd
  - [5] ififo_wr
  - [4] ififo_rd
  - [3] l0_rd
  - [2] l0_wr
  - [1] execute
  - [0] load
- `busy` out 1 — high from the cycle after an accepted start until done
- `done` out 1 — one-cycle pulse at tile completion
- `kij` out 4 — current kernel index

## Operation
- Idle word IDLE_INST = 34'h1_800C_0000: CEN/WEN for both memories high, all other bits 0. It is driven in every cycle not listed below.
- `ififo_wr`/`ififo_rd` are always 0.
- States and sequence: IDLE -> W_RD -> W_LOAD -> W_GAP -> A_RD -> EXEC -> DRAIN. DRAIN then loops to W_RD with kij+1, or goes to ACC after kij = LEN_KIJ-1. ACC -> FIN -> IDLE.
- **W_RD**: COL+1 cycles.
  - Cycle c < COL: CEN_xmem=0, WEN_xmem=1, A_xmem=W_BASE+kij*COL+c.
  - Cycle c ≥ 1: l0_wr=1. The 1-cycle SRAM latency aligns D_xmem with l0_wr.
- **W_LOAD**: COL cycles, l0_rd=1 and load=1.
- **W_GAP**: ROW+COL cycles of IDLE_INST, so weights settle through the array.
- **A_RD**: LEN_NIJ+1 cycles; same pattern as W_RD with A_xmem=ACT_BASE+n, n=0..LEN_NIJ-1.
- **EXEC**: LEN_NIJ cycles, l0_rd=1 and execute=1.
- **DRAIN**: counter p counts 0..LEN_NIJ-1.
  - Each cycle with ofifo_valid=1 and p<LEN_NIJ: ofifo_rd=1.
  - The following cycle: CEN_pmem=0, WEN_pmem=0, A_pmem=P_BASE+kij*LEN_NIJ+p, then p increments.
  - Exit after the write with p=LEN_NIJ-1 completes.
- **ACC**: for each o in 0..LEN_ONIJ-1, LEN_KIJ read cycles then one gap cycle.
  - Read cycle for kij k: CEN_pmem=0, WEN_pmem=1, A_pmem=P_BASE + k*LEN_NIJ + nij, where nij=(o/OUT_W + k/K_W)*IN_W + (o%OUT_W + k%K_W).
  - acc=1 is asserted the cycle after each read, aligned with pmem data.
  - The gap cycle has acc=0 and closes output o.
- **FIN**: one cycle; done=1, busy drops to 0 in the same cycle.
- `start` while busy: ignored.
- Address arithmetic is 11-bit unsigned and truncates; parameters must keep addresses below 2048.

## Timing
- Reset (reset=0), immediately and asynchronously:
  - inst=IDLE_INST, busy=0, done=0, kij=0, state=IDLE, all counters 0.
- Reset mid-tile abandons the tile; there is no resume.
- Start latency: start=1 in IDLE at edge N gives busy=1 and the first W_RD xmem read in the cycle after edge N.
- Per kij, with DRAIN not stalled: (COL+1)+COL+(ROW+COL)+(LEN_NIJ+1)+LEN_NIJ+(LEN_NIJ+1) cycles.
- ACC phase: LEN_ONIJ*(LEN_KIJ+1)+1 cycles.
- DRAIN stalls indefinitely while ofifo_valid=0. A pending pmem write always completes, even if ofifo_valid falls.
- `inst` is a flop output. No combinational path from inputs to `inst`.

## Configuration
- `SEQ_ACC_EN` defined: ACC phase present as above.
- `SEQ_ACC_EN` undefined: ACC state is removed; DRAIN of the last kij goes directly to FIN, and acc is constant 0.

## Test plan
- Reset: hold reset=0 for 3 cycles with start=1 -> inst=34'h1_800C_0000, busy=0, done=0, kij=0 throughout.
- First weight load: start pulse -> next cycle A_xmem=1024, CEN_xmem=0. l0_wr is high for 8 cycles starting one cycle later, followed by exactly 8 cycles of load=l0_rd=1.
- DRAIN stall: hold ofifo_valid=0 for 20 cycles in DRAIN -> no ofifo_rd, CEN_pmem=1. On release, 36 pmem writes at addresses kij*36+0..35.
- ACC address: output o=5, kij=4 -> A_pmem = 4*36 + (1+1)*6 + (1+1) = 158, with acc=1 the next cycle.
- Full tile with ofifo_valid=1 throughout -> exactly 9 DRAIN phases, then 161 ACC/FIN cycles. done pulses once, busy falls with it, and a start asserted during busy is ignored.
- Async reset asserted mid-EXEC -> inst returns to idle within the same cycle with no clock edge. A subsequent start restarts at kij=0.
